// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding and feeds IF/ID through an output register plus a one-entry skid buffer.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN (adds fetch_err_o).
module pc_fetch #(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] NOP_INST = DW'(32'h0000_0013),
    parameter int            TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_flag_i,
    input  logic          jump_en_i,
    input  logic [DW-1:0] jump_addr_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_valid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic [DW-1:0] inst_o,
    output logic [DW-1:0] inst_addr_o,
    output logic          inst_valid_o
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic          fetch_err_o
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

    state_e        state_q;
    logic [DW-1:0] pc_q, addr_q;
    logic          req_q;
    logic          o_valid_q, b_valid_q;
    logic [DW-1:0] o_inst_q, o_addr_q, b_inst_q, b_addr_q;

    logic          consume_d, o_left_d, b_left_d;
    logic [DW-1:0] pc_plus4_d, jump_tgt_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign fetch_err_o = err_q;
`endif

    // Occupancy as seen after this cycle's consume; B shifts into O when O drains.
    always_comb begin
        consume_d  = o_valid_q & ~hold_flag_i;
        b_left_d   = b_valid_q & ~consume_d;
        o_left_d   = (o_valid_q & ~consume_d) | (consume_d & b_valid_q);
        pc_plus4_d = pc_q + DW'(4);
        jump_tgt_d = jump_addr_i & ~DW'(3);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            o_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            o_inst_q  <= NOP_INST;
            o_addr_q  <= '0;
            b_inst_q  <= NOP_INST;
            b_addr_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            if (jump_en_i) begin
                o_valid_q <= 1'b0;
                b_valid_q <= 1'b0;
                pc_q      <= jump_tgt_d;
`ifdef FETCH_TIMEOUT_EN
                cnt_q     <= '0;
`endif
                // A request still in flight must be drained before retargeting.
                if (state_q == IDLE || imem_valid_i) begin
                    req_q   <= 1'b1;
                    addr_q  <= jump_tgt_d;
                    state_q <= WAIT;
                end else begin
                    state_q <= DISCARD;
                end
            end else begin
                if (consume_d) begin
                    o_valid_q <= b_valid_q;
                    o_inst_q  <= b_inst_q;
                    o_addr_q  <= b_addr_q;
                    b_valid_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (!b_left_d) begin
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_valid_i) begin
                            pc_q <= pc_plus4_d;
`ifdef FETCH_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                            if (!o_left_d) begin
                                o_valid_q <= 1'b1;
                                o_inst_q  <= imem_rdata_i;
                                o_addr_q  <= addr_q;
                                addr_q    <= pc_plus4_d;
                            end else begin
                                b_valid_q <= 1'b1;
                                b_inst_q  <= imem_rdata_i;
                                b_addr_q  <= addr_q;
                                req_q     <= 1'b0;
                                state_q   <= IDLE;
                            end
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (cnt_q == CW'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            cnt_q   <= '0;
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                    end
                    DISCARD: begin
                        if (imem_valid_i) begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
`ifdef FETCH_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (cnt_q == CW'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            cnt_q   <= '0;
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = o_valid_q;
    assign inst_o       = o_valid_q ? o_inst_q : NOP_INST;
    assign inst_addr_o  = o_addr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a variable-latency memory returns ~addr as data, fetched addresses are queued and compared as IF/ID consumes them.
module tb_pc_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold_flag_i = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err_o;
`endif

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .hold_flag_i (hold_flag_i),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_valid_i(imem_valid_i),
        .imem_rdata_i(imem_rdata_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .inst_valid_o(inst_valid_o)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err_o (fetch_err_o)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          misses = 0;
    int          memLat = 1;
    int          memCnt = 0;
    int          respCount = 0;
    bit          memMute = 0;
    bit          stray = 0;
    bit          pending = 0;
    bit          prevHeld = 0;
    logic [31:0] prevAddr = '0;
    logic [31:0] expPc = RESET_PC;
    logic [31:0] q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One cycle: check the registered state, drive inputs and the memory at negedge, update the scoreboard, return just after the posedge.
    task automatic applyStimulus(input logic r, input logic h, input logic j, input logic [31:0] ja);
        logic [31:0] item;
        @(negedge clk);
        checkOutput("validOcc", inst_valid_o, 32'(q.size() != 0));
        if (!inst_valid_o) checkOutput("nopInst", inst_o, NOP);
        if (q.size() == 2) checkOutput("fullNoReq", imem_req_o, 0);
        if (q.size() > 2) checkOutput("occupancy", q.size(), 2);
        if (prevHeld) begin
            checkOutput("reqHold", imem_req_o, 1);
            checkOutput("addrHold", imem_addr_o, prevAddr);
        end
        rst = r; hold_flag_i = h; jump_en_i = j; jump_addr_i = ja;
        imem_valid_i = 1'b0;
        imem_rdata_i = '0;
        if (r && imem_req_o && !memMute) begin
            if (memCnt >= memLat - 1) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = ~imem_addr_o;
                memCnt = 0;
                respCount++;
            end else begin
                memCnt++;
            end
        end else if (r && stray && !imem_req_o) begin
            imem_valid_i = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
        end
        if (!r) memCnt = 0;
        prevHeld = r && imem_req_o && !imem_valid_i && !memMute;
        prevAddr = imem_addr_o;
        if (!r) begin
            q.delete();
            pending = 0;
            expPc = RESET_PC;
        end else if (j) begin
            q.delete();
            pending = imem_req_o && !imem_valid_i;
            expPc = ja & ~32'd3;
        end else begin
            if (inst_valid_o && !h && q.size() > 0) begin
                item = q.pop_front();
                checkOutput("instAddr", inst_addr_o, item);
                checkOutput("instData", inst_o, ~item);
            end
            if (imem_valid_i && imem_req_o) begin
                if (pending) pending = 0;
                else begin
                    checkOutput("fetchAddr", imem_addr_o, expPc);
                    q.push_back(imem_addr_o);
                    expPc = expPc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rstReq", imem_req_o, 0);
        checkOutput("rstAddr", imem_addr_o, RESET_PC);
        checkOutput("rstValid", inst_valid_o, 0);
        checkOutput("rstInst", inst_o, NOP);
        checkOutput("rstInstAddr", inst_addr_o, 0);
    endtask

    task automatic runUntilValid(input string tag, input logic [31:0] expAddr);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1, 0, 0, 0);
            found = inst_valid_o;
        end
        checkOutput({tag, "Seen"}, 32'(found), 1);
        checkOutput({tag, "Addr"}, inst_addr_o, expAddr);
    endtask

    initial begin
        int  steps;
        bit  found;
        repeat (2) @(posedge clk);
        #1;
        checkReset();

        // Back-to-back fetch with single-cycle memory, then a 3-cycle hold at 0x8.
        applyStimulus(1, 0, 0, 0);
        checkOutput("firstReq", imem_req_o, 1);
        checkOutput("firstAddr", imem_addr_o, RESET_PC);
        steps = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1, 0, 0, 0);
            steps++;
            found = inst_valid_o && inst_addr_o == 32'h8;
        end
        checkOutput("reach8", 32'(found), 1);
        checkOutput("latency", steps, 3);
        checkOutput("respCount", respCount, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("holdAddr", inst_addr_o, 32'h8);
            checkOutput("holdInst", inst_o, ~32'h8);
            checkOutput("holdReq", imem_req_o, 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("skidAddr", inst_addr_o, 32'hC);
        checkOutput("resumeReq", imem_req_o, 1);
        checkOutput("resumeAddr", imem_addr_o, 32'h10);

        // Jump while a slow request to 0x20 is outstanding.
        memLat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1, 0, 0, 0);
            found = imem_req_o && imem_addr_o == 32'h20;
        end
        checkOutput("reach20", 32'(found), 1);
        applyStimulus(1, 0, 1, 32'h0000_0102);
        checkOutput("jmpValid", inst_valid_o, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1, 0, 0, 0);
            found = imem_req_o && imem_addr_o == 32'h100;
        end
        checkOutput("reqTarget", 32'(found), 1);
        runUntilValid("jmpFirst", 32'h100);

        // Jump coinciding with a response and a hold.
        memLat = 1;
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkOutput("preJmpReq", imem_req_o, 1);
        applyStimulus(1, 1, 1, 32'h0000_0200);
        checkOutput("jvhValid", inst_valid_o, 0);
        checkOutput("jvhReq", imem_req_o, 1);
        checkOutput("jvhAddr", imem_addr_o, 32'h200);
        runUntilValid("jvhFirst", 32'h200);

        // PC wraps past the top of the address space.
        applyStimulus(1, 0, 1, 32'hFFFF_FFFE);
        runUntilValid("wrapFirst", 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0);
        checkOutput("wrapNext", inst_addr_o, 32'h0);

        // Reset with a request in flight, followed by a stray response.
        memLat = 3;
        repeat (2) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkReset();
        stray = 1;
        applyStimulus(1, 0, 0, 0);
        stray = 0;
        checkOutput("strayValid", inst_valid_o, 0);
        runUntilValid("postRst", RESET_PC);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: the watchdog drops and reissues the request.
        applyStimulus(0, 0, 0, 0);
        memMute = 1;
        applyStimulus(1, 0, 0, 0);
        steps = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1, 0, 0, 0);
            steps++;
            found = fetch_err_o;
        end
        checkOutput("errSeen", 32'(found), 1);
        checkOutput("errCycle", steps, 16);
        checkOutput("errReqDrop", imem_req_o, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("errPulse", fetch_err_o, 0);
        checkOutput("retryReq", imem_req_o, 1);
        checkOutput("retryAddr", imem_addr_o, RESET_PC);
        memMute = 0;
        runUntilValid("retry", RESET_PC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction fetch stage of the RV32I core. Sits directly upstream of the IF/ID pipeline register and supplies its instruction and address inputs.
- Owns the PC and issues one-outstanding fetch requests to instruction memory, which may have variable latency.
- Absorbs pipeline hold via a one-entry skid buffer. On a jump it flushes both held entries and discards any in-flight response.

Parameters:
- DW, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction driven when output is invalid (addi x0,x0,0).
- TIMEOUT, 16, watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- hold_flag_i  in  1  downstream stall; the current output is not consumed.
- jump_en_i  in  1  redirect request from EX.
- jump_addr_i  in  DW  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  DW  fetch address.
- imem_valid_i  in  1  response valid; one cycle per request.
- imem_rdata_i  in  DW  response data.
- inst_o  out  DW  instruction to IF/ID.
- inst_addr_o  out  DW  PC of inst_o.
- inst_valid_o  out  1  inst_o holds a real instruction.
- fetch_err_o  out  1  only with FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC; state=IDLE; O and B empty; discard=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
  - Reset mid-request: any later imem_valid_i is ignored until a new request is issued.
- Storage: output register O (drives inst_o, inst_addr_o, inst_valid_o) and skid entry B. When O is empty, inst_o=NOP_INST.
- Consume: O is consumed when inst_valid_o & ~hold_flag_i. On consume, O<=B if B is valid, else O is empty.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if B is empty (after this cycle's consume), assert imem_req_o with imem_addr_o=pc registered, go to WAIT.
  - WAIT: imem_req_o and imem_addr_o stay stable until imem_valid_i. On response:
    - If O is empty or consumed this cycle, and B is empty: data goes into O.
    - Otherwise data goes into B.
    - pc+=4.
    - If B will be empty next cycle, issue the next request back-to-back (stay in WAIT); else go to IDLE.
  - DISCARD: keep req/addr stable. On imem_valid_i, drop the data and go to IDLE; the next request uses pc (the jump target).
- Latency: first request goes out 1 cycle after reset release. With 1-cycle memory and no hold, inst_valid_o rises the cycle after imem_valid_i, and throughput is 1 instruction/cycle.
- Jump (jump_en_i=1): highest priority, beats hold and response.
  - O and B cleared, so inst_valid_o=0 and inst_o=NOP_INST next cycle.
  - pc<=jump_addr_i with bits[1:0] forced to 0.
  - In WAIT without imem_valid_i this cycle: go to DISCARD.
  - In WAIT with imem_valid_i this cycle: the response is dropped, next request at target, state WAIT.
  - In IDLE: request at target next cycle.
  - In DISCARD: pc updated, stay in DISCARD.
- Hold: O and B contents are frozen and outputs stay stable. At most one response lands in B, after which no new request is issued.
- Occupancy: O + B never exceeds 2; never more than one request outstanding.
- pc wraps modulo 2^DW.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while imem_req_o=1 and imem_valid_i=0. It resets on response, jump, or reset.
  - When it reaches TIMEOUT, fetch_err_o pulses 1 cycle and the request is dropped: req=0, state IDLE, pc unchanged (retry next cycle).
  - A late response arriving for the dropped request is ignored.
- Undefined: no counter, no fetch_err_o port; the block waits indefinitely.

Test Plan:
- Reset release, 1-cycle memory, no hold -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; inst_addr_o follows one cycle after each response, inst_valid_o steady 1.
- hold_flag_i=1 for 3 cycles while O=inst@0x8 -> inst_o/inst_addr_o stable at 0x8; B captures 0x0C; imem_req_o low after that. Hold drops -> 0x8, then 0x0C, then request 0x10.
- jump_en_i=1, jump_addr_i=0x0000_0102 while 3-cycle-latency request to 0x20 outstanding -> response for 0x20 dropped; next imem_addr_o=0x100; inst_valid_o=0 until 0x100 returns.
- jump_en_i and imem_valid_i in the same cycle, with hold_flag_i=1 -> response dropped, O/B flushed, next request at target.
- rst=0 asserted while request outstanding, stray imem_valid_i after release -> ignored; first inst_addr_o=RESET_PC.
- With FETCH_TIMEOUT_EN, TIMEOUT=16, memory never responds -> fetch_err_o pulses at cycle 16 of waiting, request reissued to the same pc.
